// File: rtl/dsp_pkg.sv
// Shared definitions for the biquad controller: FSM states, coefficient indices
// and the default coefficient count.
package dsp_pkg;

  localparam int NUM_COEFS_DEF = 5;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } bq_state_e;

endpackage

// File: rtl/biquad_coef_bank.sv
// Coefficient storage: host-written staging bank plus a shadow bank that is
// snapshotted from staging in one edge, so later host writes cannot disturb a load.
module biquad_coef_bank
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COEFS  = NUM_COEFS_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en_i,
  input  logic [2:0]                   wr_addr_i,
  input  logic signed [DATA_WIDTH-1:0] wr_data_i,
  input  logic                         snapshot_i,
  input  logic [2:0]                   rd_idx_i,
  output logic signed [DATA_WIDTH-1:0] rd_data_o
);

  logic signed [DATA_WIDTH-1:0] staging_q [NUM_COEFS];
  logic signed [DATA_WIDTH-1:0] shadow_q  [NUM_COEFS];

  // Snapshot captures staging as it was before this edge's host write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_COEFS; i++) begin
        staging_q[i] <= '0;
        shadow_q[i]  <= '0;
      end
    end else begin
      if (wr_en_i && (32'(wr_addr_i) < NUM_COEFS)) begin
        staging_q[wr_addr_i] <= wr_data_i;
      end
      if (snapshot_i) begin
        for (int i = 0; i < NUM_COEFS; i++) begin
          shadow_q[i] <= staging_q[i];
        end
      end
    end
  end

  assign rd_data_o = shadow_q[rd_idx_i];

endmodule

// File: rtl/biquad_ctrl.sv
// Biquad engine controller: one-deep sample hold, coefficient commit/load
// sequencing and busy handshake. Optional overrun counter: BIQUAD_CTRL_OVERRUN_COUNT_EN.
module biquad_ctrl
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COEFS  = NUM_COEFS_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         host_wr,
  input  logic [2:0]                   host_addr,
  input  logic signed [DATA_WIDTH-1:0] host_data,
  input  logic                         host_commit,
  output logic                         bq_start,
  input  logic                         bq_ready,
  output logic signed [DATA_WIDTH-1:0] bq_sample,
  output logic signed [DATA_WIDTH-1:0] bq_param,
  output logic [2:0]                   bq_param_target,
  output logic                         bq_write_param,
  output logic                         commit_pending,
  output logic                         sample_done,
  output logic                         overrun,
`ifdef BIQUAD_CTRL_OVERRUN_COUNT_EN
  output logic [7:0]                   overrun_count,
`endif
  input  logic                         overrun_clear
);

  bq_state_e state_q, state_d;

  logic                         hold_full_q;
  logic signed [DATA_WIDTH-1:0] hold_data_q;
  logic signed [DATA_WIDTH-1:0] bq_sample_q;
  logic                         sample_done_q, sample_done_d;
  logic                         overrun_q;
  logic                         pending_q;
  logic [2:0]                   idx_q;
  logic                         wait_cnt_q;

  logic snapshot;
  logic enter_start;
  logic release_hold;
  logic accept;
  logic drop;
  logic last_coef;

  // The hold register frees up in START, so a strobe that cycle is accepted.
  assign release_hold = (state_q == ST_START);
  assign accept       = sample_valid && (!hold_full_q || release_hold);
  assign drop         = sample_valid && hold_full_q && !release_hold;
  assign last_coef    = (idx_q == 3'(NUM_COEFS - 1));

  always_comb begin
    state_d       = state_q;
    snapshot      = 1'b0;
    enter_start   = 1'b0;
    sample_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A strobe arriving this cycle may start directly, keeping latency at one edge.
        if ((hold_full_q || sample_valid) && bq_ready) begin
          state_d     = ST_START;
          enter_start = 1'b1;
        end else if (pending_q && bq_ready) begin
          state_d  = ST_LOAD;
          snapshot = 1'b1;
        end
      end
      ST_LOAD: begin
        if (last_coef) state_d = ST_IDLE;
      end
      ST_START: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!bq_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (wait_cnt_q) begin
          state_d       = ST_IDLE;
          sample_done_d = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (bq_ready) begin
          state_d       = ST_IDLE;
          sample_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      hold_full_q   <= 1'b0;
      hold_data_q   <= '0;
      bq_sample_q   <= '0;
      sample_done_q <= 1'b0;
      overrun_q     <= 1'b0;
      pending_q     <= 1'b0;
      idx_q         <= '0;
      wait_cnt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_done_q <= sample_done_d;
      wait_cnt_q    <= (state_q == ST_WAIT_BUSY);
      idx_q         <= (state_q == ST_LOAD && !last_coef) ? idx_q + 3'd1 : 3'd0;

      if (accept) begin
        hold_full_q <= 1'b1;
        hold_data_q <= sample_in;
      end else if (release_hold) begin
        hold_full_q <= 1'b0;
      end

      if (enter_start) begin
        bq_sample_q <= hold_full_q ? hold_data_q : sample_in;
      end

      if (snapshot) begin
        pending_q <= 1'b0;
      end else if (host_commit) begin
        pending_q <= 1'b1;
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (overrun_clear) begin
        overrun_q <= 1'b0;
      end
    end
  end

`ifdef BIQUAD_CTRL_OVERRUN_COUNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_cnt_q <= '0;
    end else if (overrun_clear) begin
      ovr_cnt_q <= drop ? 8'd1 : 8'd0;
    end else if (drop && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign overrun_count = ovr_cnt_q;
`endif

  biquad_coef_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_COEFS  (NUM_COEFS)
  ) u_coef_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en_i    (host_wr),
    .wr_addr_i  (host_addr),
    .wr_data_i  (host_data),
    .snapshot_i (snapshot),
    .rd_idx_i   (idx_q),
    .rd_data_o  (bq_param)
  );

  assign bq_start        = (state_q == ST_START);
  assign bq_write_param  = (state_q == ST_LOAD);
  assign bq_param_target = idx_q;
  assign bq_sample       = bq_sample_q;
  assign commit_pending  = pending_q;
  assign sample_done     = sample_done_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_biquad_ctrl.sv
// Directed and randomized bench for biquad_ctrl with a transaction-level reference
// model (staged coefficient array, expected-sample queue, overrun flag/count).
module tb_biquad_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        host_wr = 1'b0;
  logic [2:0]  host_addr = '0;
  logic [15:0] host_data = '0;
  logic        host_commit = 1'b0;
  logic        overrun_clear = 1'b0;
  logic        eng_ready = 1'b1;

  wire         bq_start;
  wire [15:0]  bq_sample;
  wire [15:0]  bq_param;
  wire [2:0]   bq_param_target;
  wire         bq_write_param;
  wire         commit_pending;
  wire         sample_done;
  wire         overrun;
`ifdef BIQUAD_CTRL_OVERRUN_COUNT_EN
  wire [7:0]   overrun_count;
`endif

  biquad_ctrl #(.DATA_WIDTH(16), .NUM_COEFS(5)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sample_valid    (sample_valid),
    .sample_in       (sample_in),
    .host_wr         (host_wr),
    .host_addr       (host_addr),
    .host_data       (host_data),
    .host_commit     (host_commit),
    .bq_start        (bq_start),
    .bq_ready        (eng_ready),
    .bq_sample       (bq_sample),
    .bq_param        (bq_param),
    .bq_param_target (bq_param_target),
    .bq_write_param  (bq_write_param),
    .commit_pending  (commit_pending),
    .sample_done     (sample_done),
    .overrun         (overrun),
`ifdef BIQUAD_CTRL_OVERRUN_COUNT_EN
    .overrun_count   (overrun_count),
`endif
    .overrun_clear   (overrun_clear)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] stg_m [5];
  logic [15:0] exp_q [$];
  logic        ovr_m = 1'b0;
  int          ovr_cnt_m = 0;

  // Engine model: ready drops on bq_start for busy_cfg cycles (0 = never drops).
  int busy_cfg = 6;
  int busy_left = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      eng_ready = 1'b1;
      busy_left = 0;
    end else if (bq_start && busy_cfg > 0) begin
      eng_ready = 1'b0;
      busy_left = busy_cfg;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) eng_ready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      n_cmp++;
      assert (!(bq_start && bq_write_param)) else begin
        n_fail++;
        $error("FAIL start_vs_param: observed start=%0b write_param=%0b expected not both", bq_start, bq_write_param);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic host_write(input logic [2:0] a, input logic [15:0] d);
    host_wr = 1'b1; host_addr = a; host_data = d;
    tick();
    host_wr = 1'b0;
    if (a < 3'd5) stg_m[a] = d;
  endtask

  task automatic chk_ovr();
    chk("overrun", 16'(overrun), 16'(ovr_m));
`ifdef BIQUAD_CTRL_OVERRUN_COUNT_EN
    chk("overrun_count", 16'(overrun_count), 16'(ovr_cnt_m));
`endif
  endtask

  task automatic clear_overrun();
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    ovr_m = 1'b0;
    ovr_cnt_m = 0;
    chk_ovr();
  endtask

  // Expects a full coefficient load of exp_set; inject writes staging mid-load.
  task automatic wait_load(input logic [15:0] exp_set [5], input bit inject);
    int t = 0;
    while (!bq_write_param && t < 40) begin tick(); t++; end
    chk("pending_fell", 16'(commit_pending), 16'd0);
    for (int i = 0; i < 5; i++) begin
      chk("write_param", 16'(bq_write_param), 16'd1);
      chk("param_target", 16'(bq_param_target), 16'(i));
      chk("param_value", bq_param, exp_set[i]);
      if (inject && i == 0) begin host_wr = 1'b1; host_addr = 3'd0; host_data = 16'h5555; end
      if (inject && i == 1) begin host_wr = 1'b1; host_addr = 3'd4; host_data = 16'h6666; end
      tick();
      host_wr = 1'b0;
      if (inject && i == 0) stg_m[0] = 16'h5555;
      if (inject && i == 1) stg_m[4] = 16'h6666;
    end
    chk("load_end", 16'(bq_write_param), 16'd0);
  endtask

  task automatic commit_and_load(input bit inject);
    logic [15:0] exp_set [5];
    for (int i = 0; i < 5; i++) exp_set[i] = stg_m[i];
    host_commit = 1'b1;
    tick();
    host_commit = 1'b0;
    chk("pending_set", 16'(commit_pending), 16'd1);
    wait_load(exp_set, inject);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!sample_done && t < 60) begin tick(); t++; end
    chk("done_pulse", 16'(sample_done), 16'd1);
    tick();
    chk("done_single", 16'(sample_done), 16'd0);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      int t = 0;
      logic [15:0] e;
      e = exp_q.pop_front();
      while (!bq_start && t < 60) begin tick(); t++; end
      chk("held_start", 16'(bq_start), 16'd1);
      chk("held_sample", bq_sample, e);
      wait_done();
    end
  endtask

  // One sample, then n_extra strobes while the engine is busy: the first is
  // held, the rest are dropped.
  task automatic send_sample(input logic [15:0] val, input int busy, input int n_extra);
    logic [15:0] x;
    busy_cfg = busy;
    sample_valid = 1'b1; sample_in = val;
    tick();
    sample_valid = 1'b0;
    chk("start_latency", 16'(bq_start), 16'd1);
    chk("bq_sample", bq_sample, val);
    for (int j = 0; j < n_extra; j++) begin
      tick();
      x = 16'($urandom);
      sample_valid = 1'b1; sample_in = x;
      if (j == 0) exp_q.push_back(x);
      else begin
        ovr_m = 1'b1;
        if (ovr_cnt_m < 255) ovr_cnt_m++;
      end
    end
    if (n_extra > 0) begin
      tick();
      sample_valid = 1'b0;
    end
    wait_done();
    drain();
    chk_ovr();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    for (int i = 0; i < 5; i++) stg_m[i] = '0;

    // Reset state
    tick(); tick();
    chk("rst_start", 16'(bq_start), 16'd0);
    chk("rst_write_param", 16'(bq_write_param), 16'd0);
    chk("rst_done", 16'(sample_done), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);
    chk("rst_pending", 16'(commit_pending), 16'd0);
    chk("rst_sample", bq_sample, 16'd0);
    chk("rst_param", bq_param, 16'd0);
    chk("rst_target", 16'(bq_param_target), 16'd0);
    reset_n = 1'b1;
    tick();

    // Coefficient load of a known set
    host_write(3'd0, 16'h1000);
    host_write(3'd1, 16'h2000);
    host_write(3'd2, 16'h1000);
    host_write(3'd3, 16'h0800);
    host_write(3'd4, 16'h0400);
    host_write(3'd6, 16'hDEAD);
    commit_and_load(1'b0);

    // Full-scale sample, 6-cycle busy engine
    send_sample(16'h7FFF, 6, 0);

    // Commit and sample together: sample first, load after sample_done
    host_write(3'd2, 16'hABCD);
    busy_cfg = 6;
    sample_valid = 1'b1; sample_in = 16'h8001; host_commit = 1'b1;
    tick();
    sample_valid = 1'b0; host_commit = 1'b0;
    chk("both_start", 16'(bq_start), 16'd1);
    chk("both_sample", bq_sample, 16'h8001);
    chk("both_pending", 16'(commit_pending), 16'd1);
    begin
      logic [15:0] exp_set [5];
      for (int i = 0; i < 5; i++) exp_set[i] = stg_m[i];
      wait_done();
      wait_load(exp_set, 1'b0);
    end

    // Three strobes in one busy period
    send_sample(16'h0123, 10, 3);
    clear_overrun();

    // Strobe in the START cycle is accepted, not an overrun
    a = 16'h4321; b = 16'hF00D;
    busy_cfg = 6;
    sample_valid = 1'b1; sample_in = a;
    tick();
    chk("rel_start", 16'(bq_start), 16'd1);
    chk("rel_sample", bq_sample, a);
    sample_in = b;
    tick();
    sample_valid = 1'b0;
    exp_q.push_back(b);
    wait_done();
    drain();
    chk_ovr();

    // Host write during LOAD affects only the next commit
    commit_and_load(1'b1);
    commit_and_load(1'b0);

    // Randomized mix
    for (int it = 0; it < 25; it++) begin
      int nw, busy, nx;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) host_write(3'($urandom_range(0, 7)), 16'($urandom));
      if ($urandom_range(0, 1) == 1) commit_and_load(1'b0);
      busy = $urandom_range(0, 9);
      nx = (busy >= 6) ? $urandom_range(0, 3) : 0;
      send_sample(16'($urandom), busy, nx);
      if ($urandom_range(0, 3) == 0) clear_overrun();
    end

    // Reset in WAIT_DONE with a held sample, a pending commit and overrun set
    busy_cfg = 20;
    sample_valid = 1'b1; sample_in = 16'h2468;
    tick();
    sample_valid = 1'b0;
    chk("pre_rst_start", 16'(bq_start), 16'd1);
    tick(); tick();
    sample_valid = 1'b1; sample_in = 16'h1111; host_commit = 1'b1;
    tick();
    sample_in = 16'h2222; host_commit = 1'b0;
    tick();
    sample_valid = 1'b0;
    tick();
    chk("pre_rst_overrun", 16'(overrun), 16'd1);
    chk("pre_rst_pending", 16'(commit_pending), 16'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_start", 16'(bq_start), 16'd0);
    chk("arst_write_param", 16'(bq_write_param), 16'd0);
    chk("arst_done", 16'(sample_done), 16'd0);
    chk("arst_overrun", 16'(overrun), 16'd0);
    chk("arst_pending", 16'(commit_pending), 16'd0);
    chk("arst_sample", bq_sample, 16'd0);
    chk("arst_param", bq_param, 16'd0);
    chk("arst_target", 16'(bq_param_target), 16'd0);
`ifdef BIQUAD_CTRL_OVERRUN_COUNT_EN
    chk("arst_overrun_count", 16'(overrun_count), 16'd0);
`endif
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) stg_m[i] = '0;
    exp_q.delete();
    ovr_m = 1'b0;
    ovr_cnt_m = 0;
    busy_cfg = 6;
    begin
      int activity = 0;
      for (int c = 0; c < 30; c++) begin
        tick();
        if (sample_done || bq_start || bq_write_param) activity++;
      end
      chk("post_rst_quiet", 16'(activity), 16'd0);
    end
    chk_ovr();
    commit_and_load(1'b0);
    send_sample(16'h5A5A, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
